// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling ratio, receiver FSM states and the
// baud divider calculation used by both receiver and transmitter.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    // Clocks per oversample tick (integer division).
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud_rate);
        return clk_freq / (baud_rate * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running oversample tick generator.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   tick : one-clk pulse every DIV clocks, high while the counter sits at DIV-1
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD_RATE = 115_200
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD_RATE);
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 1) begin : g_div_check
        $error("baud_tick_gen: CLK_FREQ too low for BAUD_RATE*16");
    end

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // Wrap at DIV-1 back to zero.
    always_comb begin
        cnt_next = cnt + CW'(1);
        if (cnt == CW'(DIV - 1)) begin
            cnt_next = '0;
        end
    end

    // Tick is registered from the next count so it is high while cnt == DIV-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            tick <= (cnt_next == CW'(DIV - 1));
        end
    end

endmodule

// File: rtl/uart_byte_receiver.sv
// 16x oversampling UART byte receiver.
//   clk                  : system clock
//   rst                  : asynchronous active-high reset
//   rx                   : asynchronous serial input, idle high
//   byteFromRx           : last correctly framed byte
//   rxByteReady          : high when no frame is in progress
//   new_rx_byte_indicate : one-clk pulse on a confirmed start bit
//   frame_error          : last frame had a low stop bit
module uart_byte_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned UART_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic [UART_WIDTH-1:0] byteFromRx,
    output logic                  rxByteReady,
    output logic                  new_rx_byte_indicate,
    output logic                  frame_error
);

    localparam int unsigned BW = (UART_WIDTH > 1) ? $clog2(UART_WIDTH) : 1;

    logic            tick;
    logic [1:0]      sync;
    logic            rx_s;
    rx_state_t       state, state_next;
    logic [3:0]      samp, samp_next;
    logic [BW-1:0]   bit_cnt, bit_cnt_next;
    logic [UART_WIDTH-1:0] shift, shift_next;
    logic [UART_WIDTH-1:0] byte_next;
    logic            ready_next;
    logic            ind_next;
    logic            fe_next;

    baud_tick_gen #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // Two-flop synchronizer, reset to the idle level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rx};
        end
    end

    assign rx_s = sync[1];

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= IDLE;
            samp                 <= '0;
            bit_cnt              <= '0;
            shift                <= '0;
            byteFromRx           <= '0;
            rxByteReady          <= 1'b1;
            new_rx_byte_indicate <= 1'b0;
            frame_error          <= 1'b0;
        end else begin
            state                <= state_next;
            samp                 <= samp_next;
            bit_cnt              <= bit_cnt_next;
            shift                <= shift_next;
            byteFromRx           <= byte_next;
            rxByteReady          <= ready_next;
            new_rx_byte_indicate <= ind_next;
            frame_error          <= fe_next;
        end
    end

    // Next-state and output logic; counters only move on tick.
    always_comb begin
        state_next   = state;
        samp_next    = samp;
        bit_cnt_next = bit_cnt;
        shift_next   = shift;
        byte_next    = byteFromRx;
        ready_next   = rxByteReady;
        ind_next     = 1'b0;
        fe_next      = frame_error;

        unique case (state)
            IDLE: begin
                if (tick && !rx_s) begin
                    state_next = START;
                    samp_next  = '0;
                end
            end
            START: begin
                if (tick) begin
                    samp_next = samp + 4'd1;
                    // Decide on the tick where the count reaches 7 (mid start bit).
                    if (samp == 4'd6) begin
                        samp_next    = '0;
                        bit_cnt_next = '0;
                        if (!rx_s) begin
                            state_next = DATA;
                            ind_next   = 1'b1;
                            ready_next = 1'b0;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    samp_next = samp + 4'd1;
                    if (samp == 4'd15) begin
                        samp_next  = '0;
                        shift_next = {rx_s, shift[UART_WIDTH-1:1]};
                        if (bit_cnt == BW'(UART_WIDTH - 1)) begin
                            bit_cnt_next = '0;
                            state_next   = STOP;
                        end else begin
                            bit_cnt_next = bit_cnt + BW'(1);
                        end
                    end
                end
            end
            STOP: begin
                // Leaves at mid stop bit so the next start edge is never missed.
                if (tick) begin
                    samp_next = samp + 4'd1;
                    if (samp == 4'd15) begin
                        samp_next  = '0;
                        ready_next = 1'b1;
                        if (rx_s) begin
                            byte_next  = shift;
                            fe_next    = 1'b0;
                            state_next = IDLE;
                        end else begin
                            fe_next    = 1'b1;
                            state_next = WAIT_HIGH;
                        end
                    end
                end
            end
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Directed bench for uart_byte_receiver at 32 clk per bit.
module tb_uart_byte_receiver;

    localparam int unsigned CLK_FREQ  = 3_200_000;
    localparam int unsigned BAUD_RATE = 100_000;
    localparam int unsigned W         = 8;
    localparam int unsigned BIT_CLKS  = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         rx;
    logic [W-1:0] byteFromRx;
    logic         rxByteReady;
    logic         new_rx_byte_indicate;
    logic         frame_error;

    int errors = 0;
    int checks = 0;

    int   cyc = 0;
    int   ind_cnt = 0;
    int   ind_cyc = 0;
    int   rise_cnt = 0;
    int   rise_cyc = 0;
    int   byte_cyc = 0;
    logic ready_prev = 1'b1;
    logic [W-1:0] byte_prev = '0;
    logic ready_low_seen = 1'b0;

    uart_byte_receiver #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .UART_WIDTH(W)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .rx                  (rx),
        .byteFromRx          (byteFromRx),
        .rxByteReady         (rxByteReady),
        .new_rx_byte_indicate(new_rx_byte_indicate),
        .frame_error         (frame_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (new_rx_byte_indicate === 1'b1) begin
            ind_cnt = ind_cnt + 1;
            ind_cyc = cyc;
        end
        if (rxByteReady === 1'b1 && ready_prev === 1'b0) begin
            rise_cnt = rise_cnt + 1;
            rise_cyc = cyc;
        end
        if (rxByteReady === 1'b0) ready_low_seen = 1'b1;
        if (byteFromRx !== byte_prev) byte_cyc = cyc;
        ready_prev = rxByteReady;
        byte_prev  = byteFromRx;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic stop, output int fall_cyc);
        fall_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < int'(W); i++) drive_bit(d[i]);
        drive_bit(stop);
        rx = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * BIT_CLKS) @(posedge clk);
        #1;
    endtask

    initial begin
        int fall;
        int lat;
        int ind0;
        int rise0;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_byte",  32'(byteFromRx), 32'h00);
        check("rst_ready", 32'(rxByteReady), 32'd1);
        check("rst_ind",   32'(new_rx_byte_indicate), 32'd0);
        check("rst_fe",    32'(frame_error), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_bits(2);

        // Frame 0xA5 with a good stop bit.
        ind0 = ind_cnt;
        ready_low_seen = 1'b0;
        send_frame(8'hA5, 1'b1, fall);
        idle_bits(1);
        check("a5_ind_count", 32'(ind_cnt - ind0), 32'd1);
        lat = ind_cyc - fall;
        check("a5_ind_latency_16_22", 32'(lat >= 16 && lat <= 22), 32'd1);
        lat = rise_cyc - fall;
        check("a5_ready_latency_298_312", 32'(lat >= 298 && lat <= 312), 32'd1);
        check("a5_ready_with_byte", 32'(rise_cyc == byte_cyc), 32'd1);
        check("a5_ready_went_low", 32'(ready_low_seen), 32'd1);
        check("a5_byte", 32'(byteFromRx), 32'hA5);
        check("a5_fe",   32'(frame_error), 32'd0);

        // Short glitch must be rejected.
        ind0 = ind_cnt;
        ready_low_seen = 1'b0;
        rx = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        idle_bits(2);
        check("glitch_ind",   32'(ind_cnt - ind0), 32'd0);
        check("glitch_ready", 32'(ready_low_seen), 32'd0);
        check("glitch_byte",  32'(byteFromRx), 32'hA5);

        // Bad stop bit keeps the old byte, then a good frame clears the error.
        send_frame(8'h3C, 1'b0, fall);
        idle_bits(2);
        check("3c_fe",   32'(frame_error), 32'd1);
        check("3c_byte", 32'(byteFromRx), 32'hA5);
        send_frame(8'h01, 1'b1, fall);
        idle_bits(1);
        check("01_byte", 32'(byteFromRx), 32'h01);
        check("01_fe",   32'(frame_error), 32'd0);

        // Back-to-back frames with single stop bits.
        ind0  = ind_cnt;
        rise0 = rise_cnt;
        send_frame(8'h00, 1'b1, fall);
        check("b2b_first_byte", 32'(byteFromRx), 32'h00);
        send_frame(8'hFF, 1'b1, fall);
        idle_bits(1);
        check("b2b_ind_count",  32'(ind_cnt - ind0), 32'd2);
        check("b2b_rise_count", 32'(rise_cnt - rise0), 32'd2);
        check("b2b_second_byte", 32'(byteFromRx), 32'hFF);

        // Reset during data bit 4 of 0x77, then a clean 0x5A.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1 & (8'h77 >> i));
        rx = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_byte",  32'(byteFromRx), 32'h00);
        check("midrst_ready", 32'(rxByteReady), 32'd1);
        check("midrst_ind",   32'(new_rx_byte_indicate), 32'd0);
        check("midrst_fe",    32'(frame_error), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_bits(2);
        ind0 = ind_cnt;
        send_frame(8'h5A, 1'b1, fall);
        idle_bits(1);
        check("5a_byte",      32'(byteFromRx), 32'h5A);
        check("5a_ind_count", 32'(ind_cnt - ind0), 32'd1);
        check("5a_fe",        32'(frame_error), 32'd0);

        // Line held low for 20 bit times: one start, one frame error.
        ind0  = ind_cnt;
        rise0 = rise_cnt;
        rx = 1'b0;
        repeat (20 * BIT_CLKS) @(posedge clk);
        #1;
        idle_bits(2);
        check("break_ind_count",  32'(ind_cnt - ind0), 32'd1);
        check("break_rise_count", 32'(rise_cnt - rise0), 32'd1);
        check("break_fe",         32'(frame_error), 32'd1);
        check("break_byte",       32'(byteFromRx), 32'h5A);
        idle_bits(3);
        check("break_no_more_ind", 32'(ind_cnt - ind0), 32'd1);
        send_frame(8'hC3, 1'b1, fall);
        idle_bits(1);
        check("c3_byte", 32'(byteFromRx), 32'hC3);
        check("c3_fe",   32'(frame_error), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
